ascon_arbiter: RTL and testbench
================================

# ascon_arbiter

Round-robin arbiter that shares a single ASCON-AEAD128 core among NREQ requesters. It grants the core to one requester per job and latches that requester's AD/DI sizes so they stay stable for the whole job. It holds the core's level start, muxes the input data stream, and returns the core to idle on completion, abort or watchdog timeout. It sits between the requester ports and the core's start/size/data handshake inputs.

## Interface
- NREQ, 2: number of requesters (2..8).
- SIZE_WIDTH, 32: width of AD/DI byte-size fields; matches the core.
- DW, 32: input data word width.
- TIMEOUT, 1024: watchdog limit in cycles without progress (≥2).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  NREQ  per-requester job request (level).
- req_ad_size_i  in  NREQ*SIZE_WIDTH  per-requester AD size, flattened, index 0 in LSBs.
- req_di_size_i  in  NREQ*SIZE_WIDTH  per-requester DI size, flattened.
- req_data_i  in  NREQ*DW  per-requester data word, flattened.
- req_valid_i  in  NREQ  per-requester data valid.
- req_ready_o  out  NREQ  per-requester data ready.
- grant_o  out  NREQ  one-hot grant; requesters qualify broadcast core outputs (ciphertext, tag) with it.
- done_o  out  NREQ  one-cycle job-complete pulse to owner.
- err_o  out  NREQ  one-cycle watchdog-abort pulse to owner.
- core_start_o  out  1  core start (level).
- core_ad_size_o / core_di_size_o  out  SIZE_WIDTH  latched sizes.
- core_data_o  out  DW  muxed data; core_valid_o  out  1; core_ready_i  in  1.
- core_idle_i, core_done_i  in  1  core status.

## Operation
- States: IDLE, GRANT, BUSY, FINISH, DRAIN.
- IDLE: if core_idle_i and any req_i, pick the first requesting index strictly after ptr, cyclically. Latch owner, sizes and ptr := owner. Go to GRANT. Otherwise stay.
- GRANT (1 cycle): go to BUSY.
- BUSY:
  - core_done_i → FINISH.
  - else !req_i[owner] → DRAIN (abort; no done_o pulse).
  - else watchdog hit → DRAIN with err_o[owner] pulse.
- FINISH: done_o[owner] pulses on the entry cycle only. Stay until !req_i[owner], then go to DRAIN.
- DRAIN: core_start_o low. Wait for core_idle_i, then go to IDLE.
- core_start_o = 1 in GRANT, BUSY and FINISH; 0 in IDLE and DRAIN.
- grant_o[owner] = 1 in GRANT, BUSY and FINISH.
- Data mux, active in BUSY only; all zero elsewhere:
  - core_valid_o = req_valid_i[owner], core_data_o = req_data_i[owner];
  - req_ready_o[owner] = core_ready_i;
  - non-owner ready = 0.
- Watchdog counter:
  - cleared on GRANT entry and on every core_valid_o & core_ready_i handshake;
  - increments each cycle in BUSY, saturating;
  - hit when count == TIMEOUT-1 with no handshake that cycle.
- Sizes and owner are frozen from the IDLE→GRANT edge until IDLE is re-entered; req_*_size_i changes are ignored meanwhile.
- Core sizes are driven from the latched registers; the core evaluates them combinationally throughout the job.

## Timing
- Reset values:
  - all outputs 0; state IDLE; owner 0; sizes 0; counter 0;
  - ptr = NREQ-1, so index 0 wins first.
- Request latency: req_i sampled high in IDLE at edge t gives grant_o and core_start_o high from t+1.
- Done latency: core_done_i high in BUSY at edge t gives done_o from t+1 for exactly 1 cycle.
- Turnaround:
  - FINISH→DRAIN on the edge where req_i[owner] is sampled low;
  - DRAIN→IDLE when core_idle_i is sampled high;
  - next GRANT follows ≥1 cycle after IDLE entry.
- Simultaneous core_done_i and req_i drop in BUSY: done wins, FINISH is entered and done_o pulses. The next cycle the FINISH→DRAIN exit applies.
- Simultaneous done and watchdog hit: done wins, no err_o.
- Core mid-permutation when start drops: DRAIN waits indefinitely for core_idle_i. The watchdog is not active in DRAIN.
- Reset mid-job: immediate return to IDLE, all outputs 0 asynchronously.
- Requests arriving while not in IDLE are held pending (level). There is no queue depth beyond the req_i level.

## Test plan
- Single job: req_i=01, sizes AD=16/DI=32, core_done_i after 40 cycles → grant_o=01 at t+1, done_o[0] 1 cycle, core_start_o low after req drop, IDLE once core_idle_i=1.
- Contention: req_i=11 held, 3 jobs → grants 0,1,0, with ptr updated each time.
- Size freeze: change req_ad_size_i[0] from 16 to 5 mid-job → core_ad_size_o stays 16.
- Abort: req_i[1] dropped in BUSY → no done_o, DRAIN, then IDLE only after core_idle_i.
- Watchdog: TIMEOUT=8, no handshake and no done → err_o[owner] 8 cycles after GRANT, start low.
- Reset in BUSY → all outputs 0 immediately; first grant after reset goes to index 0.

Source files
------------

// File: rtl/ascon_arbiter_if.sv
// Handshake bundle between ascon_arbiter, its requesters and the shared ASCON core.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface ascon_arbiter_if #(
  parameter int NREQ       = 2,
  parameter int SIZE_WIDTH = 32,
  parameter int DW         = 32
);
  logic [NREQ-1:0]            req_i;
  logic [NREQ*SIZE_WIDTH-1:0] req_ad_size_i;
  logic [NREQ*SIZE_WIDTH-1:0] req_di_size_i;
  logic [NREQ*DW-1:0]         req_data_i;
  logic [NREQ-1:0]            req_valid_i;
  logic [NREQ-1:0]            req_ready_o;
  logic [NREQ-1:0]            grant_o;
  logic [NREQ-1:0]            done_o;
  logic [NREQ-1:0]            err_o;
  logic                       core_start_o;
  logic [SIZE_WIDTH-1:0]      core_ad_size_o;
  logic [SIZE_WIDTH-1:0]      core_di_size_o;
  logic [DW-1:0]              core_data_o;
  logic                       core_valid_o;
  logic                       core_ready_i;
  logic                       core_idle_i;
  logic                       core_done_i;

  modport master (
    input  req_i, req_ad_size_i, req_di_size_i, req_data_i, req_valid_i,
    input  core_ready_i, core_idle_i, core_done_i,
    output req_ready_o, grant_o, done_o, err_o,
    output core_start_o, core_ad_size_o, core_di_size_o, core_data_o, core_valid_o
  );

  modport slave (
    output req_i, req_ad_size_i, req_di_size_i, req_data_i, req_valid_i,
    output core_ready_i, core_idle_i, core_done_i,
    input  req_ready_o, grant_o, done_o, err_o,
    input  core_start_o, core_ad_size_o, core_di_size_o, core_data_o, core_valid_o
  );
endinterface

// File: rtl/ascon_arbiter.sv
// Round-robin arbiter sharing one ASCON-AEAD128 core among NREQ requesters:
// per-job grant, frozen job sizes, BUSY-only data mux and a no-progress watchdog.
module ascon_arbiter #(
  parameter int NREQ       = 2,
  parameter int SIZE_WIDTH = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  ascon_arbiter_if.master bus
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   WD_LAST = CW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE     = NREQ'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_BUSY   = 3'd2,
    ST_FINISH = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  state_t                state_r, state_nxt_s;
  logic [OW-1:0]         owner_r, ptr_r, pick_s, owner_nxt_s;
  logic                  pick_valid_s, launch_s, owner_req_s;
  logic                  hs_s, hit_s, done_nxt_s, err_nxt_s, start_nxt_s;
  logic [SIZE_WIDTH-1:0] ad_size_r, di_size_r;
  logic [CW-1:0]         wd_r;
  logic [NREQ-1:0]       grant_r, done_r, err_r, ready_s;
  logic                  start_r, valid_s;
  logic [DW-1:0]         data_s;

  assign owner_req_s = bus.req_i[owner_r];
  assign hs_s        = valid_s & bus.core_ready_i;
  assign hit_s       = (wd_r == WD_LAST) & ~hs_s;
  assign launch_s    = (state_r == ST_IDLE) & (state_nxt_s == ST_GRANT);
  assign owner_nxt_s = launch_s ? pick_s : owner_r;
  assign start_nxt_s = (state_nxt_s == ST_GRANT) | (state_nxt_s == ST_BUSY) |
                       (state_nxt_s == ST_FINISH);

  // Round-robin pick: scan from the farthest offset down so the nearest one after ptr wins.
  always_comb begin
    pick_s       = '0;
    pick_valid_s = |bus.req_i;
    for (int k = NREQ; k >= 1; k--) begin
      if (bus.req_i[(int'(ptr_r) + k) % NREQ]) begin
        pick_s = OW'((int'(ptr_r) + k) % NREQ);
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; completion has priority over abort, abort over watchdog.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.core_idle_i && pick_valid_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: state_nxt_s = ST_BUSY;
      ST_BUSY: begin
        if (bus.core_done_i) begin
          state_nxt_s = ST_FINISH;
          done_nxt_s  = 1'b1;
        end else if (!owner_req_s) begin
          state_nxt_s = ST_DRAIN;
        end else if (hit_s) begin
          state_nxt_s = ST_DRAIN;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_FINISH: begin
        if (!owner_req_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FINISH;
        end
      end
      ST_DRAIN: begin
        if (bus.core_idle_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Owner data path, open only while the job is running.
  always_comb begin
    valid_s = 1'b0;
    data_s  = '0;
    ready_s = '0;
    if (state_r == ST_BUSY) begin
      valid_s          = bus.req_valid_i[owner_r];
      data_s           = bus.req_data_i[int'(owner_r) * DW +: DW];
      ready_s[owner_r] = bus.core_ready_i;
    end else begin
      valid_s = 1'b0;
    end
  end

  // Watchdog: cycles in BUSY since the last accepted data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r <= '0;
    end else if (launch_s || hs_s) begin
      wd_r <= '0;
    end else if ((state_r == ST_BUSY) && (wd_r != WD_LAST)) begin
      wd_r <= wd_r + 1'b1;
    end else begin
      wd_r <= wd_r;
    end
  end

  // Owner, pointer and sizes are captured only on the IDLE to GRANT edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r   <= '0;
      ptr_r     <= OW'(NREQ - 1);
      ad_size_r <= '0;
      di_size_r <= '0;
    end else if (launch_s) begin
      owner_r   <= pick_s;
      ptr_r     <= pick_s;
      ad_size_r <= bus.req_ad_size_i[int'(pick_s) * SIZE_WIDTH +: SIZE_WIDTH];
      di_size_r <= bus.req_di_size_i[int'(pick_s) * SIZE_WIDTH +: SIZE_WIDTH];
    end else begin
      owner_r   <= owner_r;
      ptr_r     <= ptr_r;
      ad_size_r <= ad_size_r;
      di_size_r <= di_size_r;
    end
  end

  // Registered grant/start/status outputs, derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r <= 1'b0;
      grant_r <= '0;
      done_r  <= '0;
      err_r   <= '0;
    end else begin
      start_r <= start_nxt_s;
      grant_r <= start_nxt_s ? (ONE << owner_nxt_s) : '0;
      done_r  <= done_nxt_s ? (ONE << owner_r) : '0;
      err_r   <= err_nxt_s ? (ONE << owner_r) : '0;
    end
  end

  assign bus.req_ready_o    = ready_s;
  assign bus.grant_o        = grant_r;
  assign bus.done_o         = done_r;
  assign bus.err_o          = err_r;
  assign bus.core_start_o   = start_r;
  assign bus.core_ad_size_o = ad_size_r;
  assign bus.core_di_size_o = di_size_r;
  assign bus.core_data_o    = data_s;
  assign bus.core_valid_o   = valid_s;

endmodule

// File: tb/tb_ascon_arbiter.sv
// Bench for ascon_arbiter: directed job table, hand-written corner sequences,
// then random traffic against a job-level reference model.
module tb_ascon_arbiter;
  localparam int NREQ = 2;
  localparam int SW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 8;

  localparam int M_FREE  = 0;
  localparam int M_GRANT = 1;
  localparam int M_RUN   = 2;
  localparam int M_FIN   = 3;
  localparam int M_DRAIN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_arbiter_if #(.NREQ(NREQ), .SIZE_WIDTH(SW), .DW(DW)) bus ();

  ascon_arbiter #(.NREQ(NREQ), .SIZE_WIDTH(SW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          n;
    logic [1:0]  req;
    logic        idle;
    logic        done;
    logic [31:0] ad0;
    logic [1:0]  exp_grant;
    logic        exp_start;
    logic [1:0]  exp_done;
    logic        exp_valid;
    logic [1:0]  exp_ready;
    logic [31:0] exp_ad;
  } vec_t;
  vec_t tbl[$];

  // reference model state
  int          m_mode, m_owner, m_ptr, m_quiet;
  logic [31:0] m_ad, m_di;
  bit          m_done, m_err;
  bit          stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input logic [1:0] exp, input string nm);
    int k;
    k = 0;
    while (bus.grant_o == 2'b00 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, bus.grant_o, exp);
  endtask

  task automatic finish_job(input logic [1:0] om, input string nm);
    @(posedge clk); #1;
    bus.core_done_i = 1'b1;
    @(posedge clk); #1;
    bus.core_done_i = 1'b0;
    @(negedge clk);
    chk({nm, "_done"}, bus.done_o, om);
    bus.req_i = 2'b11 & ~om;
    @(posedge clk); #1;
    bus.req_i = 2'b11;
    chk({nm, "_start_low"}, bus.core_start_o, 1'b0);
  endtask

  task automatic model_step();
    bit prog;
    prog   = (m_mode == M_RUN) && bus.req_valid_i[m_owner] && bus.core_ready_i;
    m_done = 1'b0;
    m_err  = 1'b0;
    case (m_mode)
      M_FREE: begin
        if (bus.core_idle_i && bus.req_i != 2'b00) begin
          for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (bus.req_i[c]) begin
              m_owner = c;
              break;
            end
          end
          m_ptr   = m_owner;
          m_ad    = bus.req_ad_size_i[m_owner*SW +: SW];
          m_di    = bus.req_di_size_i[m_owner*SW +: SW];
          m_quiet = 0;
          m_mode  = M_GRANT;
        end
      end
      M_GRANT: m_mode = M_RUN;
      M_RUN: begin
        if (bus.core_done_i) begin
          m_mode = M_FIN;
          m_done = 1'b1;
        end else if (!bus.req_i[m_owner]) begin
          m_mode = M_DRAIN;
        end else if (!prog && m_quiet == TO - 1) begin
          m_mode = M_DRAIN;
          m_err  = 1'b1;
        end
        if (prog) m_quiet = 0;
        else if (m_quiet < TO - 1) m_quiet++;
      end
      M_FIN:   if (!bus.req_i[m_owner]) m_mode = M_DRAIN;
      M_DRAIN: if (bus.core_idle_i) m_mode = M_FREE;
      default: m_mode = M_FREE;
    endcase
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NREQ; i++) begin
      if ($urandom_range(0, 9) == 0) bus.req_i[i] = ~bus.req_i[i];
    end
    if ($urandom_range(0, 19) == 0) stall = ~stall;
    bus.req_valid_i   = 2'($urandom);
    bus.core_ready_i  = stall ? 1'b0 : 1'($urandom);
    bus.core_idle_i   = ($urandom_range(0, 2) != 0);
    bus.core_done_i   = ($urandom_range(0, 15) == 0);
    bus.req_ad_size_i = {$urandom, $urandom};
    bus.req_di_size_i = {$urandom, $urandom};
    bus.req_data_i    = {$urandom, $urandom};
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    bus.req_i = 2'b00; bus.req_valid_i = 2'b11; bus.core_ready_i = 1'b1;
    bus.core_idle_i = 1'b1; bus.core_done_i = 1'b0;
    bus.req_ad_size_i = {32'd7, 32'd16}; bus.req_di_size_i = {32'd9, 32'd32};
    bus.req_data_i = {32'hB0B0_0001, 32'hA0A0_0000};
    stall = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_grant", bus.grant_o, 2'b00);
    chk("rst_start", bus.core_start_o, 1'b0);
    chk("rst_ad", bus.core_ad_size_o, 32'd0);
    chk("rst_done_err", {bus.done_o, bus.err_o}, 4'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single job, size freeze, done latency and drain
    tbl.push_back('{1,  2'b00, 1'b1, 1'b0, 32'd16, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0});
    tbl.push_back('{1,  2'b01, 1'b1, 1'b0, 32'd16, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0});
    tbl.push_back('{1,  2'b01, 1'b1, 1'b0, 32'd16, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 32'd16});
    tbl.push_back('{1,  2'b01, 1'b1, 1'b0, 32'd5,  2'b01, 1'b1, 2'b00, 1'b1, 2'b01, 32'd16});
    tbl.push_back('{37, 2'b01, 1'b1, 1'b0, 32'd5,  2'b01, 1'b1, 2'b00, 1'b1, 2'b01, 32'd16});
    tbl.push_back('{1,  2'b01, 1'b1, 1'b1, 32'd5,  2'b01, 1'b1, 2'b00, 1'b1, 2'b01, 32'd16});
    tbl.push_back('{1,  2'b01, 1'b1, 1'b0, 32'd5,  2'b01, 1'b1, 2'b01, 1'b0, 2'b00, 32'd16});
    tbl.push_back('{2,  2'b01, 1'b1, 1'b0, 32'd5,  2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 32'd16});
    tbl.push_back('{1,  2'b00, 1'b0, 1'b0, 32'd5,  2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 32'd16});
    tbl.push_back('{4,  2'b00, 1'b0, 1'b0, 32'd5,  2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'd16});
    tbl.push_back('{1,  2'b00, 1'b1, 1'b0, 32'd5,  2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'd16});
    tbl.push_back('{2,  2'b00, 1'b1, 1'b0, 32'd5,  2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 32'd16});
    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        @(posedge clk); #1;
        bus.req_i = tbl[i].req; bus.core_idle_i = tbl[i].idle; bus.core_done_i = tbl[i].done;
        bus.req_ad_size_i[31:0] = tbl[i].ad0;
        @(negedge clk);
        chk($sformatf("row%0d_grant", i), bus.grant_o, tbl[i].exp_grant);
        chk($sformatf("row%0d_start", i), bus.core_start_o, tbl[i].exp_start);
        chk($sformatf("row%0d_done", i), bus.done_o, tbl[i].exp_done);
        chk($sformatf("row%0d_err", i), bus.err_o, 2'b00);
        chk($sformatf("row%0d_valid", i), bus.core_valid_o, tbl[i].exp_valid);
        chk($sformatf("row%0d_ready", i), bus.req_ready_o, tbl[i].exp_ready);
        chk($sformatf("row%0d_ad", i), bus.core_ad_size_o, tbl[i].exp_ad);
        if (tbl[i].exp_start) chk($sformatf("row%0d_di", i), bus.core_di_size_o, 32'd32);
      end
    end

    // reset in BUSY: outputs clear at once, then index 0 wins first
    bus.req_i = 2'b10;
    wait_grant(2'b10, "pre_reset_grant");
    repeat (2) @(negedge clk);
    chk("busy_valid", bus.core_valid_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", bus.grant_o, 2'b00);
    chk("arst_start", bus.core_start_o, 1'b0);
    chk("arst_valid_ready", {bus.core_valid_o, bus.req_ready_o}, 3'b000);
    chk("arst_ad", bus.core_ad_size_o, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.req_i = 2'b11;

    // contention: grants 0,1,0
    wait_grant(2'b01, "cont0_grant");
    finish_job(2'b01, "cont0");
    wait_grant(2'b10, "cont1_grant");
    finish_job(2'b10, "cont1");
    wait_grant(2'b01, "cont2_grant");
    finish_job(2'b01, "cont2");

    // abort by requester 1, drain waits for core idle
    bus.req_i = 2'b10;
    wait_grant(2'b10, "abort_grant");
    @(posedge clk); #1;
    bus.req_i = 2'b00; bus.core_idle_i = 1'b0;
    @(posedge clk); #1;
    bus.req_i = 2'b01; bus.req_valid_i = 2'b00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_drain_start", bus.core_start_o, 1'b0);
      chk("abort_drain_grant", bus.grant_o, 2'b00);
      chk("abort_no_done", bus.done_o, 2'b00);
    end
    bus.core_idle_i = 1'b1;
    @(negedge clk);
    chk("abort_idle_nogrant", bus.grant_o, 2'b00);
    @(negedge clk);
    chk("wd_grant", bus.grant_o, 2'b01);

    // watchdog: no handshake, no done
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        chk("wd_err", bus.err_o, 2'b01);
        chk("wd_start_low", bus.core_start_o, 1'b0);
      end else begin
        chk($sformatf("wd_err_c%0d", k), bus.err_o, 2'b00);
        if (k < 9) chk($sformatf("wd_start_c%0d", k), bus.core_start_o, 1'b1);
      end
    end
    bus.req_i = 2'b00;
    repeat (4) @(negedge clk);

    // random traffic against the reference model
    rst_n = 1'b0;
    m_mode = M_FREE; m_owner = 0; m_ptr = NREQ - 1; m_quiet = 0;
    m_ad = '0; m_di = '0; m_done = 1'b0; m_err = 1'b0;
    randomize_inputs();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      logic [1:0] oh;
      bit         act, run;
      @(posedge clk);
      model_step();
      #1;
      randomize_inputs();
      @(negedge clk);
      oh = 2'b00;
      oh[m_owner] = 1'b1;
      act = (m_mode == M_GRANT) || (m_mode == M_RUN) || (m_mode == M_FIN);
      run = (m_mode == M_RUN);
      chk($sformatf("rnd%0d_grant", c), bus.grant_o, act ? oh : 2'b00);
      chk($sformatf("rnd%0d_start", c), bus.core_start_o, act);
      chk($sformatf("rnd%0d_done", c), bus.done_o, m_done ? oh : 2'b00);
      chk($sformatf("rnd%0d_err", c), bus.err_o, m_err ? oh : 2'b00);
      chk($sformatf("rnd%0d_valid", c), bus.core_valid_o, run ? bus.req_valid_i[m_owner] : 1'b0);
      chk($sformatf("rnd%0d_ready", c), bus.req_ready_o, (run && bus.core_ready_i) ? oh : 2'b00);
      chk($sformatf("rnd%0d_data", c), bus.core_data_o, run ? bus.req_data_i[m_owner*DW +: DW] : 32'd0);
      chk($sformatf("rnd%0d_ad", c), bus.core_ad_size_o, m_ad);
      chk($sformatf("rnd%0d_di", c), bus.core_di_size_o, m_di);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
